bandai_mapper_p: RTL and testbench



---
 rtl/bandai_mapper_pkg.sv | 26 ++
 rtl/bandai_mapper_p_bus_write_sync.sv | 46 ++++
 rtl/bandai_mapper_p.sv | 172 +++++++++++++++++
 tb/tb_bandai_mapper_p.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bandai_mapper_pkg.sv
// Shared constants and unlock-FSM types for the Bandai cartridge mapper.
package bandai_mapper_pkg;

    localparam logic [7:0] RegLao   = 8'hC0;
    localparam logic [7:0] RegRamb  = 8'hC1;
    localparam logic [7:0] RegRomb0 = 8'hC2;
    localparam logic [7:0] RegMctrl = 8'hCE;

    localparam int unsigned McByteBit = 0;
    localparam int unsigned McWpBit   = 1;

    localparam logic [15:0]             DefSeq       = 16'h5AA5;
    localparam int unsigned             DefStreamLen = 18;
    localparam logic [DefStreamLen-1:0] DefStream    = {1'b0, 16'h28A0, 1'b0};

    // Step counter supports unlock sequences of up to 16 addresses.
    localparam int unsigned StepW = 4;

    typedef enum logic {ModeLocked, ModeOpen} mode_e;

    typedef struct packed {
        mode_e            mode;
        logic [StepW-1:0] step;
    } state_t;

endpackage

// File: rtl/bandai_mapper_p_bus_write_sync.sv
// Synchronises the async WEn/OEn strobes and turns a completed write into a
// one-cycle commit pulse carrying the address/data latched while WEn was low.
module bus_write_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_n_i,
    input  logic       oe_n_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    input  logic       iosel_i,
    output logic       commit_o,
    output logic [7:0] addr_o,
    output logic [7:0] data_o
);

    logic [1:0] we_sync_q, oe_sync_q;
    logic       we_prev_q;
    logic [7:0] addr_q, data_q;
    logic       iosel_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_sync_q <= 2'b11;
            oe_sync_q <= 2'b11;
            we_prev_q <= 1'b1;
            addr_q    <= '0;
            data_q    <= '0;
            iosel_q   <= 1'b0;
        end else begin
            we_sync_q <= {we_sync_q[0], we_n_i};
            oe_sync_q <= {oe_sync_q[0], oe_n_i};
            we_prev_q <= we_sync_q[1];
            if (!we_sync_q[1]) begin
                addr_q  <= addr_i;
                data_q  <= data_i;
                iosel_q <= iosel_i;
            end
        end
    end

    // A write overlapping an active read is bus contention; drop it.
    assign commit_o = we_sync_q[1] & ~we_prev_q & iosel_q & oe_sync_q[1];
    assign addr_o   = addr_q;
    assign data_o   = data_q;

endmodule

// File: rtl/bandai_mapper_p.sv
// Bandai cartridge mapper: address-sequence unlock, boot bit-stream, bank
// registers and console address decode into chip selects / upper address.
module bandai_mapper_p
    import bandai_mapper_pkg::*;
#(
    parameter int unsigned               NUM_ROMB    = 2,
    parameter int unsigned               RADDR_W     = 7,
    parameter int unsigned               SEQ_LEN     = 2,
    parameter logic [SEQ_LEN*8-1:0]      SEQ         = DefSeq,
    parameter int unsigned               STREAM_LEN  = DefStreamLen,
    parameter logic [STREAM_LEN-1:0]     STREAM      = DefStream,
    parameter bit                        BYTEMODE_EN = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CEn,
    input  logic               SSn,
    input  logic               WEn,
    input  logic               OEn,
    input  logic [7:0]         ADDR,
    input  logic [7:0]         DQ_I,
    output logic [7:0]         DQ_O,
    output logic               DQ_OE,
    output logic               SO,
    output logic               SO_OE,
    output logic               ROMCEn,
    output logic               RAMCEn,
    output logic               BYTEn,
    output logic [RADDR_W-1:0] RADDR,
    output logic               LOCKED
);

    state_t                state_q, state_d;
    logic                  load;
    logic [7:0]            exp_byte;
    logic [STREAM_LEN-1:0] sr_q;
    logic                  so_oe_q;

    logic [7:0] lao_q, ramb_q;
    logic [7:0] romb_q [NUM_ROMB];
    logic       byte_q, wp_q;

    logic       open, iosel, rce, byte_n, ram_ce, rom_ce;
    logic [3:0] seg;
    logic       wr_commit;
    logic [7:0] wr_addr, wr_data;
    logic       rd_hit;
    logic [7:0] rd_val, rom_bank;

    assign open  = (state_q.mode == ModeOpen);
    assign iosel = ~(SSn & CEn);
    assign seg   = ADDR[7:4];

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        exp_byte = SEQ[(int'(SEQ_LEN) - 1 - int'(state_q.step)) * 8 +: 8];
        if (state_q.mode == ModeLocked) begin
            if (ADDR == exp_byte) begin
                if (state_q.step == StepW'(SEQ_LEN - 1)) begin
                    state_d.mode = ModeOpen;
                    state_d.step = '0;
                    load         = 1'b1;
                end else begin
                    state_d.step = state_q.step + 1'b1;
                end
            end else if (ADDR == SEQ[SEQ_LEN*8-1 -: 8]) begin
                state_d.step = StepW'(1);
            end else begin
                state_d.step = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= '{mode: ModeLocked, step: '0};
            sr_q    <= '1;
            so_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= load ? STREAM : {1'b1, sr_q[STREAM_LEN-1:1]};
            so_oe_q <= 1'b1;
        end
    end

    bus_write_sync u_wsync (
        .clk_i    (CLK),
        .rst_i    (RST),
        .we_n_i   (WEn),
        .oe_n_i   (OEn),
        .addr_i   (ADDR),
        .data_i   (DQ_I),
        .iosel_i  (iosel),
        .commit_o (wr_commit),
        .addr_o   (wr_addr),
        .data_o   (wr_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            lao_q  <= 8'hFF;
            ramb_q <= 8'hFF;
            for (int i = 0; i < NUM_ROMB; i++) romb_q[i] <= 8'hFF;
            byte_q <= 1'b0;
            wp_q   <= 1'b0;
        end else if (open && wr_commit) begin
            if (wr_addr == RegLao)  lao_q  <= wr_data;
            if (wr_addr == RegRamb) ramb_q <= wr_data;
            for (int i = 0; i < NUM_ROMB; i++) begin
                if (wr_addr == RegRomb0 + 8'(i)) romb_q[i] <= wr_data;
            end
            if (wr_addr == RegMctrl) begin
                byte_q <= BYTEMODE_EN & wr_data[McByteBit];
                wp_q   <= wr_data[McWpBit];
            end
        end
    end

    always_comb begin
        rd_hit = 1'b1;
        rd_val = '0;
        if (ADDR == RegLao) begin
            rd_val = lao_q;
        end else if (ADDR == RegRamb) begin
            rd_val = ramb_q;
        end else if (ADDR == RegMctrl) begin
            rd_val = {6'b0, wp_q, byte_q};
        end else begin
            rd_hit = 1'b0;
            for (int i = 0; i < NUM_ROMB; i++) begin
                if (ADDR == RegRomb0 + 8'(i)) begin
                    rd_hit = 1'b1;
                    rd_val = romb_q[i];
                end
            end
        end
    end

    assign DQ_OE = open & iosel & ~OEn & WEn & rd_hit;
    assign DQ_O  = rd_val;

    assign byte_n = BYTEMODE_EN ? ~byte_q : 1'b1;
    assign rce    = open & SSn & ~CEn;
    // Write-protected RAM is deselected only while the console is writing.
    assign ram_ce = rce & (seg == 4'd1) & byte_n & ~(wp_q & ~WEn);
    assign rom_ce = rce & ((seg >= 4'd2) | ((seg == 4'd1) & ~byte_n));

    always_comb begin
        rom_bank = '0;
        for (int i = 0; i < NUM_ROMB; i++) begin
            if (seg == 4'(i + 2)) rom_bank = romb_q[i];
        end
        if (!(ram_ce || rom_ce)) begin
            RADDR = '0;
        end else if (seg > 4'(1 + NUM_ROMB)) begin
            RADDR = {lao_q[RADDR_W-5:0], seg};
        end else if (seg == 4'd1) begin
            RADDR = ramb_q[RADDR_W-1:0];
        end else begin
            RADDR = rom_bank[RADDR_W-1:0];
        end
    end

    assign RAMCEn = ~ram_ce;
    assign ROMCEn = ~rom_ce;
    assign BYTEn  = byte_n;
    assign SO     = sr_q[0];
    assign SO_OE  = so_oe_q;
    assign LOCKED = ~open;

endmodule

// File: tb/tb_bandai_mapper_p.sv
// Directed plus randomized bench for bandai_mapper_p against a register-level model.
module tb_bandai_mapper_p;

    logic       CLK = 1'b0, RST = 1'b1;
    logic       CEn = 1'b1, SSn = 1'b1, WEn = 1'b1, OEn = 1'b1;
    logic [7:0] ADDR = 8'h00, DQ_I = 8'h00;
    logic [7:0] DQ_O;
    logic       DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, BYTEn, LOCKED;
    logic [6:0] RADDR;

    int vectors = 0, miscompares = 0;

    // Reference state
    logic       m_open;
    logic [7:0] m_lao, m_ramb;
    logic [7:0] m_romb [2];
    logic       m_byte, m_wp;
    // Boot stream {0, 16'h28A0, 0} read out LSB first
    int exp_bits [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};
    logic [7:0] addr_tbl [7] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hCE, 8'hC8, 8'hC4};

    bandai_mapper_p dut (
        .CLK    (CLK),
        .RST    (RST),
        .CEn    (CEn),
        .SSn    (SSn),
        .WEn    (WEn),
        .OEn    (OEn),
        .ADDR   (ADDR),
        .DQ_I   (DQ_I),
        .DQ_O   (DQ_O),
        .DQ_OE  (DQ_OE),
        .SO     (SO),
        .SO_OE  (SO_OE),
        .ROMCEn (ROMCEn),
        .RAMCEn (RAMCEn),
        .BYTEn  (BYTEn),
        .RADDR  (RADDR),
        .LOCKED (LOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_open  = 1'b0;
        m_lao   = 8'hFF;
        m_ramb  = 8'hFF;
        m_romb[0] = 8'hFF;
        m_romb[1] = 8'hFF;
        m_byte  = 1'b0;
        m_wp    = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ADDR = a; DQ_I = d; CEn = 1'b0; SSn = 1'b0; WEn = 1'b0;
        repeat (4) tick();
        WEn = 1'b1;
        repeat (4) tick();
        CEn = 1'b1; SSn = 1'b1; ADDR = 8'h00;
        tick();
        if (m_open) begin
            case (a)
                8'hC0: m_lao = d;
                8'hC1: m_ramb = d;
                8'hC2: m_romb[0] = d;
                8'hC3: m_romb[1] = d;
                8'hCE: begin m_byte = d[0]; m_wp = d[1]; end
                default: ;
            endcase
        end
    endtask

    task automatic rd(input logic [7:0] a, input string tag);
        logic       hit;
        logic [7:0] val;
        ADDR = a; CEn = 1'b0; SSn = 1'b0; WEn = 1'b1; OEn = 1'b0;
        #1;
        hit = m_open;
        val = 8'h00;
        case (a)
            8'hC0: val = m_lao;
            8'hC1: val = m_ramb;
            8'hC2: val = m_romb[0];
            8'hC3: val = m_romb[1];
            8'hCE: val = {6'b0, m_wp, m_byte};
            default: hit = 1'b0;
        endcase
        check({tag, ".dq_oe"}, DQ_OE, hit);
        if (hit) check({tag, ".dq_o"}, DQ_O, val);
        OEn = 1'b1; CEn = 1'b1; SSn = 1'b1;
        #1;
    endtask

    task automatic acc(input logic [3:0] seg, input logic we_low, input string tag);
        logic e_rom, e_ram;
        int   e_addr;
        ADDR = {seg, 4'($urandom_range(0, 15))}; SSn = 1'b1; CEn = 1'b0; WEn = ~we_low; OEn = 1'b1;
        #1;
        e_ram = m_open && seg == 4'd1 && !m_byte && !(m_wp && we_low);
        e_rom = m_open && (seg >= 4'd2 || (seg == 4'd1 && m_byte));
        if (!(e_ram || e_rom))  e_addr = 0;
        else if (seg > 4'd3)    e_addr = (int'(m_lao) % 8) * 16 + int'(seg);
        else if (seg == 4'd1)   e_addr = int'(m_ramb) % 128;
        else                    e_addr = int'(m_romb[int'(seg) - 2]) % 128;
        check({tag, ".romcen"}, ROMCEn, !e_rom);
        check({tag, ".ramcen"}, RAMCEn, !e_ram);
        check({tag, ".raddr"}, RADDR, e_addr);
        check({tag, ".byten"}, BYTEn, !m_byte);
        CEn = 1'b1; WEn = 1'b1; ADDR = 8'h00;
        #1;
    endtask

    initial begin
        model_reset();
        // Reset state
        RST = 1'b1;
        repeat (2) tick();
        check("rst.locked", LOCKED, 1);
        check("rst.so", SO, 1);
        check("rst.so_oe", SO_OE, 0);
        acc(4'd2, 1'b0, "rst.seg2");
        rd(8'hC0, "rst.rd");
        RST = 1'b0;
        tick();
        check("post_rst.so_oe", SO_OE, 1);

        // Broken sequence must not unlock
        ADDR = 8'h5A; tick();
        ADDR = 8'h33; tick();
        ADDR = 8'hA5; tick();
        ADDR = 8'h00; tick();
        check("bad_seq.locked", LOCKED, 1);
        acc(4'd3, 1'b0, "locked.seg3");

        // Repeated first byte keeps step 1, then unlock
        ADDR = 8'h5A; tick();
        ADDR = 8'h5A; tick();
        ADDR = 8'hA5; tick();
        m_open = 1'b1;
        ADDR = 8'h00;
        check("unlock.locked", LOCKED, 0);
        check("stream.bit0", SO, exp_bits[0]);
        for (int i = 1; i < 18; i++) begin
            tick();
            check($sformatf("stream.bit%0d", i), SO, exp_bits[i]);
        end
        repeat (3) begin
            tick();
            check("stream.tail", SO, 1);
        end

        // Directed register writes and decode
        wr(8'hC2, 8'h12);
        acc(4'd2, 1'b0, "romb0");
        rd(8'hC2, "rd.c2");
        wr(8'hC0, 8'h05);
        acc(4'd7, 1'b0, "lao");
        wr(8'hC1, 8'h03);
        acc(4'd1, 1'b0, "ramb");
        acc(4'd0, 1'b0, "seg0");

        // Randomized writes, accesses and readbacks
        for (int n = 0; n < 10; n++) begin
            logic [7:0] a;
            a = addr_tbl[$urandom_range(0, 6)];
            wr(a, 8'($urandom));
            acc(4'($urandom_range(0, 15)), 1'($urandom), "rand.acc");
            acc(4'd1, 1'($urandom), "rand.seg1");
            rd(a, "rand.rd");
        end

        // Byte mode steers segment 1 to ROM on both reads and writes
        wr(8'hCE, 8'h03);
        acc(4'd1, 1'b0, "byte.rd");
        acc(4'd1, 1'b1, "byte.wr");
        rd(8'hCE, "rd.mctrl");

        // Write-protect without byte mode deselects RAM only on writes
        wr(8'hCE, 8'h02);
        acc(4'd1, 1'b0, "wp.rd");
        acc(4'd1, 1'b1, "wp.wr");

        // Reset mid-stream, then unlock again
        RST = 1'b1; tick(); RST = 1'b0; tick();
        model_reset();
        ADDR = 8'h5A; tick();
        ADDR = 8'hA5; tick();
        ADDR = 8'h00;
        m_open = 1'b1;
        check("re.locked", LOCKED, 0);
        check("re.bit0", SO, exp_bits[0]);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("re.bit%0d", i), SO, exp_bits[i]);
        end
        RST = 1'b1;
        tick();
        model_reset();
        check("midrst.so", SO, 1);
        check("midrst.locked", LOCKED, 1);
        RST = 1'b0;
        tick();
        ADDR = 8'h5A; tick();
        ADDR = 8'hA5; tick();
        ADDR = 8'h00;
        m_open = 1'b1;
        check("re2.locked", LOCKED, 0);
        rd(8'hC0, "re2.lao");
        rd(8'hC3, "re2.romb1");
        rd(8'hCE, "re2.mctrl");
        acc(4'd5, 1'b0, "re2.seg5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
